// File: rtl/btn_event_pkg.sv
// Shared event codes, hold-timer state encoding and index-width helper for btn_event_ctrl.
// BTN_EVENT_AUTOREPEAT_EN selects the REPEAT state in place of DONE.
package btn_event_pkg;

  localparam logic [1:0] EV_RELEASE = 2'b00;
  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

`ifdef BTN_EVENT_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, ARMED, REPEAT} hold_state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED, DONE} hold_state_t;
`endif

  function automatic int unsigned iw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Reader-side bus of btn_event_ctrl: mask load, FIFO pop and event/status outputs.
interface btn_event_ctrl_if #(
    parameter int unsigned NIN = 21
);
    localparam int unsigned IW = btn_event_pkg::iw(NIN);

    logic            i_mask_wr;
    logic [NIN-1:0]  i_mask;
    logic            i_rd;
    logic            o_valid;
    logic [IW+1:0]   o_event;
    logic            o_overflow;
    logic            o_int;

    modport master (
        output i_mask_wr, i_mask, i_rd,
        input  o_valid, o_event, o_overflow, o_int
    );

    modport slave (
        input  i_mask_wr, i_mask, i_rd,
        output o_valid, o_event, o_overflow, o_int
    );
endinterface

// File: rtl/btn_event_fifo.sv
// Event FIFO with registered head, pointer-based full/empty and sticky drop flag.
module btn_event_fifo #(
    parameter int unsigned DW     = 7,
    parameter int unsigned LGFIFO = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_overflow
);
    localparam int unsigned DEPTH = 1 << LGFIFO;

    logic [DW-1:0]   mem [DEPTH];
    logic [LGFIFO:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic            empty, full, do_push, do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[LGFIFO] != rptr[LGFIFO]) &&
                      (wptr[LGFIFO-1:0] == rptr[LGFIFO-1:0]);
    assign do_pop   = i_pop && !empty;
    assign do_push  = i_push && (!full || do_pop);
    assign wptr_nxt = wptr + {{LGFIFO{1'b0}}, do_push};
    assign rptr_nxt = rptr + {{LGFIFO{1'b0}}, do_pop};

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem[wptr[LGFIFO-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            o_valid <= (wptr_nxt != rptr_nxt);
            // The next head is either already in memory or is the word being written now.
            if (wptr_nxt != rptr_nxt)
                o_data <= (rptr_nxt == wptr) ? i_data : mem[rptr_nxt[LGFIFO-1:0]];
            if (i_push && full && !do_pop)
                o_overflow <= 1'b1;
            else if (do_pop && full)
                o_overflow <= 1'b0;
        end
    end
endmodule

// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into queued press/release/long-press events.
// Optional auto-repeat events are enabled by defining BTN_EVENT_AUTOREPEAT_EN.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int unsigned NIN    = 21,
    parameter int unsigned LGFIFO = 4,
    parameter int unsigned LGHOLD = 24,
    parameter int unsigned LGREP  = 22
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NIN-1:0]    i_debounced,
    btn_event_ctrl_if.slave   bus
);
    localparam int unsigned IW = iw(NIN);
    localparam int unsigned TW = (LGHOLD > LGREP) ? LGHOLD : LGREP;
    localparam logic [TW-1:0] HOLD_LOAD = TW'({LGHOLD{1'b1}});
`ifdef BTN_EVENT_AUTOREPEAT_EN
    localparam logic [TW-1:0] REP_LOAD  = TW'({LGREP{1'b1}});
`endif

    logic [NIN-1:0] r_prev, r_mask, pend_p, pend_r;
    logic [NIN-1:0] rise, fall, en_nxt, sel_bit, clr_p, clr_r;
    logic           p_vld, r_vld, grant, press_go;
    logic [IW-1:0]  p_idx, r_idx, sel_idx;
    logic           long_req, rep_req, hold_req, owner_on;
    logic           push;
    logic [IW+1:0]  push_data;

    hold_state_t    state, state_nxt;
    logic [IW-1:0]  owner, owner_nxt;
    logic [TW-1:0]  timer, timer_nxt;

    assign rise   = i_debounced & ~r_prev & r_mask;
    assign fall   = ~i_debounced & r_prev & r_mask;
    assign en_nxt = bus.i_mask_wr ? bus.i_mask : '1;

    // Scan from the top down so the lowest pending index wins.
    always_comb begin
        p_vld = 1'b0;
        r_vld = 1'b0;
        p_idx = '0;
        r_idx = '0;
        for (int unsigned i = NIN; i > 0; i--) begin
            if (pend_p[i-1]) begin
                p_vld = 1'b1;
                p_idx = IW'(i-1);
            end
            if (pend_r[i-1]) begin
                r_vld = 1'b1;
                r_idx = IW'(i-1);
            end
        end
    end

    assign owner_on = i_debounced[owner] & r_mask[owner];

    always_comb begin
        long_req = (state == ARMED) && (timer == '0) && owner_on;
        rep_req  = 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
        rep_req  = (state == REPEAT) && (timer == '0) && owner_on;
`endif
    end

    assign hold_req  = long_req | rep_req;
    assign grant     = (p_vld | r_vld) & ~hold_req;
    assign press_go  = grant & p_vld;
    assign sel_idx   = p_vld ? p_idx : r_idx;
    assign sel_bit   = NIN'(1) << sel_idx;
    assign clr_p     = press_go ? sel_bit : '0;
    assign clr_r     = (grant && !p_vld) ? sel_bit : '0;
    assign push      = hold_req | grant;
    assign push_data = hold_req ? {(long_req ? EV_LONG : EV_REPEAT), owner}
                                : {(p_vld ? EV_PRESS : EV_RELEASE), sel_idx};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev <= i_debounced;
            r_mask <= '1;
            pend_p <= '0;
            pend_r <= '0;
        end else begin
            r_prev <= i_debounced;
            if (bus.i_mask_wr)
                r_mask <= bus.i_mask;
            pend_p <= ((pend_p & ~clr_p) | rise) & en_nxt;
            pend_r <= ((pend_r & ~clr_r) | fall) & en_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            owner <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            timer <= timer_nxt;
        end
    end

    // long_req is resolved before press_go is considered, so the two never collide.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (press_go) begin
                    owner_nxt = sel_idx;
                    timer_nxt = HOLD_LOAD;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (long_req) begin
`ifdef BTN_EVENT_AUTOREPEAT_EN
                    state_nxt = REPEAT;
                    timer_nxt = REP_LOAD;
`else
                    state_nxt = DONE;
`endif
                end else if (press_go) begin
                    owner_nxt = sel_idx;
                    timer_nxt = HOLD_LOAD;
                end else if (!owner_on) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
`ifdef BTN_EVENT_AUTOREPEAT_EN
            REPEAT: begin
                if (!owner_on)
                    state_nxt = IDLE;
                else if (rep_req)
                    timer_nxt = REP_LOAD;
                else
                    timer_nxt = timer - 1'b1;
            end
`else
            DONE: begin
                if (!i_debounced[owner])
                    state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    btn_event_fifo #(
        .DW     (IW + 2),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_push     (push),
        .i_data     (push_data),
        .i_pop      (bus.i_rd),
        .o_valid    (bus.o_valid),
        .o_data     (bus.o_event),
        .o_overflow (bus.o_overflow)
    );

    assign bus.o_int = bus.o_valid | bus.o_overflow;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: table of level steps plus hold, overflow, mask and reset sequences.
module tb_btn_event_ctrl;
    import btn_event_pkg::*;

    localparam int unsigned NIN = 21;

    typedef struct packed {
        logic [20:0]     lvl;
        logic [1:0]      n;
        logic [2:0][6:0] ev;
    } vec_t;

    logic        clk, rst_n;
    logic [20:0] dbn;
    logic        rd_en, auto_rd, man_rd;
    logic [6:0]  exp_q[$];
    int          n_checks, n_fail;
    vec_t        vecs[6];

    btn_event_ctrl_if #(.NIN(NIN)) bus ();

    btn_event_ctrl #(
        .NIN    (NIN),
        .LGFIFO (2),
        .LGHOLD (6),
        .LGREP  (4)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_debounced (dbn),
        .bus         (bus)
    );

    assign bus.i_rd = auto_rd | man_rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] mkev(input logic [1:0] c, input int unsigned i);
        return {c, 5'(i)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({nm, "_pending_events"}, exp_q.size(), 0);
        step(4);
    endtask

    // Reader: pops every valid head while enabled and compares with the scoreboard.
    initial begin
        logic [6:0] e;
        auto_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_en && bus.o_valid === 1'b1) begin
                chk("o_int_while_valid", bus.o_int, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got 0x%0h, expected none", bus.o_event);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", bus.o_event, e);
                end
                auto_rd = 1'b1;
            end else begin
                auto_rd = 1'b0;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        dbn      = 21'h000003;
        rd_en    = 1'b0;
        man_rd   = 1'b0;
        bus.i_mask_wr = 1'b0;
        bus.i_mask    = '1;

        vecs[0] = '{lvl: 21'h000027, n: 2'd2, ev: {7'h0, mkev(EV_PRESS, 5), mkev(EV_PRESS, 2)}};
        vecs[1] = '{lvl: 21'h000003, n: 2'd2, ev: {7'h0, mkev(EV_RELEASE, 5), mkev(EV_RELEASE, 2)}};
        vecs[2] = '{lvl: 21'h000001, n: 2'd1, ev: {7'h0, 7'h0, mkev(EV_RELEASE, 1)}};
        vecs[3] = '{lvl: 21'h000102, n: 2'd3, ev: {mkev(EV_RELEASE, 0), mkev(EV_PRESS, 8), mkev(EV_PRESS, 1)}};
        vecs[4] = '{lvl: 21'h100000, n: 2'd3, ev: {mkev(EV_RELEASE, 8), mkev(EV_RELEASE, 1), mkev(EV_PRESS, 20)}};
        vecs[5] = '{lvl: 21'h000000, n: 2'd1, ev: {7'h0, 7'h0, mkev(EV_RELEASE, 20)}};

        #2 rst_n = 1'b0;
        #10;
        chk("reset_o_valid", bus.o_valid, 0);
        chk("reset_o_event", bus.o_event, 0);
        chk("reset_o_overflow", bus.o_overflow, 0);
        chk("reset_o_int", bus.o_int, 0);
        step(2);
        rst_n = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(negedge clk);
            chk("idle_after_reset", bus.o_valid, 0);
        end
        step(1);

        for (int i = 0; i < 6; i++) begin
            dbn = vecs[i].lvl;
            for (int j = 0; j < int'(vecs[i].n); j++)
                exp_q.push_back(vecs[i].ev[j]);
            drain("table", 40);
        end

        // Long press on bit 7
        dbn[7] = 1'b1;
        exp_q.push_back(mkev(EV_PRESS, 7));
        exp_q.push_back(mkev(EV_LONG, 7));
        exp_q.push_back(mkev(EV_RELEASE, 7));
        step(74);
        dbn[7] = 1'b0;
        drain("long_press", 40);

        // Later press steals the hold timer
        dbn[3] = 1'b1;
        exp_q.push_back(mkev(EV_PRESS, 3));
        step(20);
        dbn[4] = 1'b1;
        exp_q.push_back(mkev(EV_PRESS, 4));
        exp_q.push_back(mkev(EV_LONG, 4));
        step(70);
        dbn[4:3] = 2'b00;
        exp_q.push_back(mkev(EV_RELEASE, 3));
        exp_q.push_back(mkev(EV_RELEASE, 4));
        drain("last_press_wins", 40);

        // Overflow: six presses into a four-deep queue with no reader
        rd_en = 1'b0;
        step(2);
        dbn[15:10] = 6'h3F;
        step(15);
        @(negedge clk);
        chk("full_o_valid", bus.o_valid, 1);
        chk("full_o_overflow", bus.o_overflow, 1);
        chk("full_o_int", bus.o_int, 1);
        chk("full_head", bus.o_event, mkev(EV_PRESS, 10));
        step(0);
        @(posedge clk);
        #1 man_rd = 1'b1;
        step(1);
        man_rd = 1'b0;
        @(negedge clk);
        chk("pop_clears_overflow", bus.o_overflow, 0);
        chk("head_after_pop", bus.o_event, mkev(EV_PRESS, 11));
        step(0);
        exp_q.push_back(mkev(EV_PRESS, 11));
        exp_q.push_back(mkev(EV_PRESS, 12));
        exp_q.push_back(mkev(EV_PRESS, 13));
        @(posedge clk);
        #1 rd_en = 1'b1;
        drain("overflow_remaining", 40);
        dbn[15:10] = 6'h00;
        for (int i = 10; i < 16; i++)
            exp_q.push_back(mkev(EV_RELEASE, i));
        drain("overflow_releases", 60);
        chk("overflow_stays_clear", bus.o_overflow, 0);

        // Masked input produces nothing
        bus.i_mask_wr = 1'b1;
        bus.i_mask    = ~21'h000002;
        step(1);
        bus.i_mask_wr = 1'b0;
        dbn[1] = 1'b1;
        step(5);
        dbn[1] = 1'b0;
        step(20);
        @(negedge clk);
        chk("masked_toggle_no_event", bus.o_valid, 0);
        step(0);
        // Edge arriving on the very cycle its input is masked is discarded
        @(posedge clk);
        #1;
        bus.i_mask_wr = 1'b1;
        bus.i_mask    = ~21'h000200;
        dbn[9] = 1'b1;
        step(1);
        bus.i_mask_wr = 1'b0;
        step(10);
        @(negedge clk);
        chk("mask_same_cycle_edge", bus.o_valid, 0);
        @(posedge clk);
        #1;
        bus.i_mask_wr = 1'b1;
        bus.i_mask    = '1;
        step(1);
        bus.i_mask_wr = 1'b0;
        step(3);
        dbn[9] = 1'b0;
        exp_q.push_back(mkev(EV_RELEASE, 9));
        drain("unmask_release", 40);

        // Hold bit 0 for 120 clocks
        dbn[0] = 1'b1;
        exp_q.push_back(mkev(EV_PRESS, 0));
        exp_q.push_back(mkev(EV_LONG, 0));
`ifdef BTN_EVENT_AUTOREPEAT_EN
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mkev(EV_REPEAT, 0));
`endif
        step(120);
        dbn[0] = 1'b0;
        exp_q.push_back(mkev(EV_RELEASE, 0));
        drain("hold_120", 40);

        // Reset with events queued and buttons held
        rd_en = 1'b0;
        step(2);
        dbn[17:16] = 2'b11;
        step(6);
        @(negedge clk);
        chk("queued_before_reset", bus.o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_o_valid", bus.o_valid, 0);
        chk("midreset_o_event", bus.o_event, 0);
        chk("midreset_o_overflow", bus.o_overflow, 0);
        chk("midreset_o_int", bus.o_int, 0);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        rd_en = 1'b1;
        step(20);
        @(negedge clk);
        chk("no_edge_after_reset", bus.o_valid, 0);
        step(0);
        @(posedge clk);
        #1 dbn[17:16] = 2'b00;
        exp_q.push_back(mkev(EV_RELEASE, 16));
        exp_q.push_back(mkev(EV_RELEASE, 17));
        drain("release_after_reset", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
